bundler_ctrl_hf: RTL

//  Sequencer in front of bundler_hf. Collects NUM_HVS hypervectors, delivered serially over a

---
 rtl/bundler_ctrl_hf.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bundler_ctrl_hf.sv
// bundler_ctrl_hf: sequencer in front of bundler_hf. It collects NUM_HVS serial hypervector
// beats into a frame buffer, fires the bundler for one cycle, waits for its result strobe
// (with a timeout), then holds the bundled HV on a valid/ready output.
// Optional feature: define BUNDLER_CTRL_PIPE_EN to keep filling the next frame while a
// result waits in HOLD.
module bundler_ctrl_hf #(
  parameter int DIMENSIONS     = 10000,
  parameter int NUM_HVS        = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DIMENSIONS-1:0]               hv_in,
  output logic                                bnd_en,
  output logic [NUM_HVS-1:0][DIMENSIONS-1:0]  bnd_hv_array,
  input  logic                                bnd_out,
  input  logic [DIMENSIONS-1:0]               bnd_hv,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DIMENSIONS-1:0]               hv_out,
  output logic                                busy,
  output logic                                err_timeout
);

  localparam int CNT_W  = $clog2(NUM_HVS + 1);
  localparam int IDX_W  = $clog2(NUM_HVS);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(NUM_HVS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
`ifdef BUNDLER_CTRL_PIPE_EN
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(NUM_HVS);
`endif

  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, HOLD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic               err_next, out_valid_next;
  logic               store, capture;
  logic [IDX_W-1:0]   slot;

  // Arrival order selects the frame slot.
  assign slot = cnt[IDX_W-1:0];
  assign busy = (state != COLLECT) || (cnt != '0);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= COLLECT;
    else       state <= state_next;
  end

  // Next-state, handshake outputs and control updates; flush overrides everything.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    bnd_en         = 1'b0;
    cnt_next       = cnt;
    wait_next      = wait_cnt;
    err_next       = err_timeout;
    out_valid_next = out_valid;
    store          = 1'b0;
    capture        = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          store    = 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == LAST) state_next = FIRE;
        end
      end
      FIRE: begin
        bnd_en    = 1'b1;
        wait_next = '0;
        if (bnd_out) begin
          capture        = 1'b1;
          out_valid_next = 1'b1;
          cnt_next       = '0;
          state_next     = HOLD;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A strobe arriving on the timeout cycle still counts as a result.
        if (bnd_out) begin
          capture        = 1'b1;
          out_valid_next = 1'b1;
          cnt_next       = '0;
          state_next     = HOLD;
        end else if (wait_cnt == WAIT_LAST) begin
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = COLLECT;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      HOLD: begin
`ifdef BUNDLER_CTRL_PIPE_EN
        in_ready = (cnt != FULL);
        if (in_valid && in_ready) begin
          store    = 1'b1;
          cnt_next = cnt + 1'b1;
        end
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = (cnt_next == FULL) ? FIRE : COLLECT;
        end
`else
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = COLLECT;
        end
`endif
      end
      default: state_next = COLLECT;
    endcase
    if (flush) begin
      state_next     = COLLECT;
      cnt_next       = '0;
      out_valid_next = 1'b0;
      err_next       = 1'b0;
      store          = 1'b0;
      capture        = 1'b0;
      bnd_en         = 1'b0;
    end
  end

  // Control registers: beat count, wait counter, sticky timeout flag, output valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt         <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      wait_cnt    <= wait_next;
      err_timeout <= err_next;
      out_valid   <= out_valid_next;
    end
  end

  // Frame buffer and result register; the frame only changes on accepted beats.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bnd_hv_array <= '0;
      hv_out       <= '0;
    end else begin
      if (store)   bnd_hv_array[slot] <= hv_in;
      if (capture) hv_out             <= bnd_hv;
    end
  end

endmodule
